// File: rtl/encoder_16to4.sv
// encoder_16to4 : registered 16-to-4 binary encoder.
//
// Compresses a one-hot (normally) 16-bit vector into the 4-bit index of the
// set bit. Multi-hot inputs resolve by priority; an all-zero input is
// reported through valid=0 with o=0.
//
// Parameters:
//   PRIORITY_HIGH  1: highest set index wins, 0: lowest set index wins.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous reset, active-high (overrides en)
//   en     in   1   capture enable
//   i      in  16   input vector
//   o      out  4   registered index of the selected bit
//   valid  out  1   registered, captured i was non-zero
//   err    out  1   registered, captured i had more than one bit set
//                   (only when ENC_ERR_EN is defined)
//
// Build option: define ENC_ERR_EN to add the err port and multi-hot detect.

module encoder_16to4 #(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] i,
  output logic [3:0]  o,
  output logic        valid
`ifdef ENC_ERR_EN
  ,
  output logic        err
`endif
);

  logic [3:0] enc;

  // Scan direction sets the priority: the last matching bit in the scan wins.
  always_comb begin
    enc = 4'd0;
    if (PRIORITY_HIGH != 0) begin
      for (int k = 0; k < 16; k++) begin
        if (i[k]) enc = 4'(k);
      end
    end else begin
      for (int k = 15; k >= 0; k--) begin
        if (i[k]) enc = 4'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o     <= 4'd0;
      valid <= 1'b0;
    end else if (en) begin
      o     <= enc;
      valid <= |i;
    end
  end

`ifdef ENC_ERR_EN
  logic multi;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(i & (i - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (en) begin
      err <= multi;
    end
  end
`endif

endmodule

// File: tb/tb_encoder_16to4.sv
module tb_encoder_16to4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] i;
  logic [3:0]  o_hi, o_lo;
  logic        valid_hi, valid_lo;
`ifdef ENC_ERR_EN
  logic        err_hi, err_lo;
`endif

  always #5 clk = ~clk;

  encoder_16to4 #(.PRIORITY_HIGH(1)) dut_hi (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i     (i),
    .o     (o_hi),
    .valid (valid_hi)
`ifdef ENC_ERR_EN
    ,
    .err   (err_hi)
`endif
  );

  encoder_16to4 #(.PRIORITY_HIGH(0)) dut_lo (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i     (i),
    .o     (o_lo),
    .valid (valid_lo)
`ifdef ENC_ERR_EN
    ,
    .err   (err_lo)
`endif
  );

  typedef struct {
    int o_hi;
    int o_lo;
    int valid;
    int err;
  } exp_t;

  exp_t sb[$];
  exp_t model = '{0, 0, 0, 0};
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // Reference: floor(log2 v) for the top bit; isolate the lowest bit via v & -v.
  function automatic int msb_index(int v);
    return (v == 0) ? 0 : $clog2(v + 1) - 1;
  endfunction

  function automatic int lsb_index(int v);
    return (v == 0) ? 0 : $clog2(v & -v);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(bit r, bit e, logic [15:0] v);
    int vi;
    @(negedge clk);
    rst = r;
    en  = e;
    i   = v;
    vi  = int'(v);
    if (r) begin
      model = '{0, 0, 0, 0};
    end else if (e) begin
      model.o_hi  = msb_index(vi);
      model.o_lo  = lsb_index(vi);
      model.valid = (vi != 0) ? 1 : 0;
      model.err   = ($countones(v) > 1) ? 1 : 0;
    end
    sb.push_back(model);
  endtask

  // Monitor: every edge presents one registered result per issued cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("o_hi",     int'(o_hi),     e.o_hi);
        check("o_lo",     int'(o_lo),     e.o_lo);
        check("valid_hi", int'(valid_hi), e.valid);
        check("valid_lo", int'(valid_lo), e.valid);
`ifdef ENC_ERR_EN
        check("err_hi",   int'(err_hi),   e.err);
        check("err_lo",   int'(err_lo),   e.err);
`endif
      end
    end
  end

  initial begin
    logic [15:0] v;
    int sel;
    rst = 1'b1;
    en  = 1'b0;
    i   = 16'h0000;

    step(1, 0, 16'h0000);
    step(1, 1, 16'hFFFF);

    for (int k = 0; k < 16; k++) step(0, 1, 16'(1 << k));

    step(0, 1, 16'h0000);
    step(0, 1, 16'h0001);
    step(0, 1, 16'h8001);
    step(0, 1, 16'h0050);

    step(0, 1, 16'h0400);
    for (int k = 0; k < 3; k++) step(0, 0, 16'h0008);

    step(0, 1, 16'h1000);
    step(1, 1, 16'h0002);
    step(0, 1, 16'h0002);
    step(0, 1, 16'hFFFF);

    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: v = 16'(1 << $urandom_range(0, 15));
        4:          v = 16'h0000;
        default:    v = 16'($urandom);
      endcase
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), v);
    end

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
    end
  end

endmodule
